// File: rtl/dpy_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner:
// scan states, the hex segment table and leading-zero detection.
package dpy_pkg;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam int MAX_DIGITS = 16;

    // Index = nibble value, bits = gfedcba, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

    // Highest digit index holding a non-zero nibble; 0 when every nibble is zero.
    function automatic logic [3:0] lz_top(input logic [4*MAX_DIGITS-1:0] num);
        logic [3:0] h;
        h = 4'd0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (num[4*i +: 4] != 4'h0) h = 4'(i);
        end
        return h;
    endfunction

endpackage

// File: rtl/dpy_decode.sv
// Nibble to 7-segment (gfedcba, active-high) lookup.
module dpy_decode
    import dpy_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg_of(i_nibble);

endmodule

// File: rtl/dpy_scan_multi.sv
// Multiplexed hex 7-segment scanner with frame snapshot, dead time, PWM,
// digit mask and leading-zero blanking. Define DPY_BLINK_EN to add per-digit blink.
module dpy_scan_multi
    import dpy_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_INTERVAL = 10_000,
    parameter int BLANK_CYCLES  = 100,
    parameter int BRIGHT_W      = 4
`ifdef DPY_BLINK_EN
    ,
    parameter int BLINK_FRAMES  = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    lz_blank,
`ifdef DPY_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    output logic [NUM_DIGITS-1:0]   digit,
    output logic [7:0]              segment,
    output logic                    frame_start
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (SCAN_INTERVAL > BLANK_CYCLES) ? SCAN_INTERVAL : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    scan_state_t             r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [BRIGHT_W-1:0]     r_pwm;
    logic [4*NUM_DIGITS-1:0] r_num;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic                    r_lz;
    logic [NUM_DIGITS-1:0]   r_digit;
    logic [7:0]              r_segment;
    logic                    r_frame_start;

    scan_state_t             w_state_next;
    logic [IDX_W-1:0]        w_idx_next;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_frame_entry;
    logic [3:0]              w_nib;
    logic [6:0]              w_seg;
    logic [3:0]              w_lz_top;
    logic                    w_lz_hide;
    logic                    w_pwm_on;
    logic                    w_blink_dark;
    logic                    w_lit;

    assign w_idx_inc = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;

    // A frame begins on whichever edge enters SHOW with idx 0.
    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_cnt_next    = r_cnt + 1'b1;
        w_frame_entry = 1'b0;
        case (r_state)
            SHOW: begin
                if (r_cnt == CNT_W'(SCAN_INTERVAL - 1)) begin
                    w_cnt_next = '0;
                    w_idx_next = w_idx_inc;
                    if (BLANK_CYCLES == 0) begin
                        w_state_next  = SHOW;
                        w_frame_entry = (w_idx_inc == '0);
                    end else begin
                        w_state_next = BLANK;
                    end
                end
            end
            BLANK: begin
                if (BLANK_CYCLES == 0 || r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    w_cnt_next    = '0;
                    w_state_next  = SHOW;
                    w_frame_entry = (r_idx == '0);
                end
            end
            default: begin
                w_state_next = BLANK;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_nib = r_num[{r_idx, 2'b00} +: 4];

    dpy_decode u_decode (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

    assign w_lz_top  = lz_top((4*MAX_DIGITS)'(r_num));
    assign w_lz_hide = r_lz && (32'(r_idx) > 32'(w_lz_top));
    assign w_pwm_on  = (brightness == '1) || (r_pwm < brightness);

`ifdef DPY_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);

    logic [NUM_DIGITS-1:0] r_blink;
    logic [FC_W-1:0]       r_fcnt;
    logic                  r_phase;

    // Phase flips once BLINK_FRAMES whole frames have been shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_frame_entry) begin
            r_blink <= blink;
            if (r_fcnt == FC_W'(BLINK_FRAMES)) begin
                r_phase <= ~r_phase;
                r_fcnt  <= FC_W'(1);
            end else begin
                r_fcnt  <= r_fcnt + 1'b1;
            end
        end
    end

    assign w_blink_dark = r_phase && r_blink[r_idx];
`else
    assign w_blink_dark = 1'b0;
`endif

    assign w_lit = (r_state == SHOW) && digit_en[r_idx] && w_pwm_on && !w_blink_dark;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BLANK;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_pwm         <= '0;
            r_num         <= '0;
            r_dp          <= '0;
            r_lz          <= 1'b0;
            r_digit       <= '0;
            r_segment     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_cnt         <= w_cnt_next;
            r_pwm         <= r_pwm + 1'b1;
            r_frame_start <= w_frame_entry;
            if (w_frame_entry) begin
                r_num <= number;
                r_dp  <= dp;
                r_lz  <= lz_blank;
            end
            r_digit   <= w_lit ? (NUM_DIGITS'(1) << r_idx) : '0;
            r_segment <= w_lit ? {r_dp[r_idx], (w_lz_hide ? 7'h00 : w_seg)} : 8'h00;
        end
    end

    assign digit       = r_digit;
    assign segment     = r_segment;
    assign frame_start = r_frame_start;

endmodule
